adc_frame_reader: RTL

Downstream consumer of the ADC ping-pong output FIFO in the 100 MHz interface domain. Waits for a bank-full indication and drains exactly one bank of NWORDS ADC words through the FIFO read port. Emits the words as a framed valid/ready stream: one header word, NWORDS data words, and one checksum trailer marked by `m_tlast`. Tracks frame sequence numbers and flags bank overruns for the host.

---
 rtl/adc_frame_reader.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/adc_frame_reader.sv
// Drains one ping-pong bank per start event and emits it as a framed stream:
// header {SYNC_WORD, seq}, NWORDS data words, then a 32-bit checksum trailer.
module adc_frame_reader #(
  parameter int          NWORDS    = 512,
  parameter logic [15:0] SYNC_WORD = 16'hA5A5
) (
  input  logic        clk_100m,
  input  logic        rst,
  input  logic        enable,
  input  logic        full_ppfifo,
  output logic        adc_out_rd,
  input  logic [31:0] data_out_adc,
  output logic [31:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic [15:0] frame_cnt,
  output logic        overrun,
  input  logic        clr_status,
  output logic        busy
);

  localparam int CW = $clog2(NWORDS + 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA, TRL} state_e;

  state_e          state_q, state_d;
  logic            full_q;
  logic            pending_q, pending_d;
  logic            overrun_q, overrun_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic [31:0]     sum_q, sum_d;
  logic [CW-1:0]   rd_left_q, rd_left_d, rd_base;
  logic [CW-1:0]   dcnt_q, dcnt_d;
  logic            rd_q, rd_d;
  logic            vld_q;
  logic [3:0][31:0] mem_q;
  logic [1:0]      wp_q, rp_q;
  logic [2:0]      occ_q, occ_d;

  logic        start, hs, push, pop;
  logic [31:0] head;

  assign start = full_ppfifo & ~full_q;
  assign head  = mem_q[rp_q];
  assign hs    = m_tvalid & m_tready;
  assign push  = vld_q;
  assign pop   = (state_q == DATA) & hs;
  assign occ_d = occ_q + 3'(push) - 3'(pop);

  always_comb begin
    m_tvalid = 1'b0;
    m_tdata  = '0;
    unique case (state_q)
      HDR:  begin m_tvalid = 1'b1;          m_tdata = {SYNC_WORD, frame_cnt_q}; end
      DATA: begin m_tvalid = (occ_q != 3'd0); m_tdata = (occ_q != 3'd0) ? head : '0; end
      TRL:  begin m_tvalid = 1'b1;          m_tdata = sum_q; end
      default: ;
    endcase
  end

  assign m_tlast    = (state_q == TRL);
  assign busy       = (state_q != IDLE);
  assign adc_out_rd = rd_q;
  assign frame_cnt  = frame_cnt_q;
  assign overrun    = overrun_q;

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    overrun_d   = overrun_q & ~clr_status;
    frame_cnt_d = frame_cnt_q;
    sum_d       = sum_q;
    dcnt_d      = dcnt_q;
    rd_base     = rd_left_q;

    // One bank may queue behind the active frame; anything beyond that is dropped.
    if (state_q != IDLE && start) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end

    unique case (state_q)
      IDLE: if (start && enable) begin
        state_d = HDR;
        rd_base = CW'(NWORDS);
      end
      HDR: if (hs) state_d = DATA;
      DATA: if (hs) begin
        sum_d = sum_q + head;
        if (dcnt_q == CW'(NWORDS - 1)) begin
          dcnt_d  = '0;
          state_d = TRL;
        end else begin
          dcnt_d = dcnt_q + CW'(1);
        end
      end
      TRL: if (hs) begin
        frame_cnt_d = frame_cnt_q + 16'd1;
        sum_d       = '0;
        // A start landing on the trailer handshake is folded into the queue slot.
        if (pending_q || start) begin
          state_d   = HDR;
          rd_base   = CW'(NWORDS);
          pending_d = pending_q & start;
          overrun_d = overrun_q & ~clr_status;
        end else begin
          state_d = IDLE;
        end
      end
      default: ;
    endcase

    // Next-cycle occupancy plus reads still in flight must leave room for this read.
    rd_d      = (rd_base != '0) && ((occ_d + 3'(rd_q)) < 3'd4);
    rd_left_d = rd_base - CW'(rd_d);
  end

  always_ff @(posedge clk_100m or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      full_q      <= 1'b0;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
      sum_q       <= '0;
      rd_left_q   <= '0;
      dcnt_q      <= '0;
      rd_q        <= 1'b0;
      vld_q       <= 1'b0;
      mem_q       <= '0;
      wp_q        <= '0;
      rp_q        <= '0;
      occ_q       <= '0;
    end else begin
      state_q     <= state_d;
      full_q      <= full_ppfifo;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
      sum_q       <= sum_d;
      rd_left_q   <= rd_left_d;
      dcnt_q      <= dcnt_d;
      rd_q        <= rd_d;
      vld_q       <= rd_q;
      occ_q       <= occ_d;
      if (push) begin
        mem_q[wp_q] <= data_out_adc;
        wp_q        <= wp_q + 2'd1;
      end
      if (pop) rp_q <= rp_q + 2'd1;
    end
  end

endmodule
